ddr_note_lanes: RTL and testbench

Parametrised note-field engine for the DDR game: a LANES × ROWS grid of lights that scrolls one row toward the target row on each advance strobe. New notes enter at the top from a spawn pattern. Key presses are judged against the bottom (target) row, producing per-lane hit/miss pulses plus saturating score and combo counters. It replaces the per-row light cells with one multi-lane, multi-row block that sits between the tempo divider (advance strobe) and the display/score logic.

---
 rtl/ddr_pkg.sv | 18 +
 rtl/ddr_note_lanes_if.sv | 17 +
 rtl/ddr_lane.sv | 43 ++++
 rtl/ddr_note_lanes.sv | 62 ++++++
 tb/tb_ddr_note_lanes.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ddr_pkg.sv
// ddr_pkg: shared defaults and counting helpers for the note-lane engine
package ddr_pkg;
  localparam int LANES_DEF = 4;
  localparam int ROWS_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int MAX_LANES = 8;
  function automatic logic [3:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) n = n + 4'(v[i]);
    return n;
  endfunction
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [3:0] b, input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {29'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction
endpackage

// File: rtl/ddr_note_lanes_if.sv
// ddr_note_lanes_if: stimulus and display/score bundle of the note-lane engine
interface ddr_note_lanes_if import ddr_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic adv;
  logic [LANES-1:0] spawn;
  logic [LANES-1:0] key;
  logic [LANES*ROWS-1:0] lights;
  logic [LANES-1:0] hit;
  logic [LANES-1:0] miss;
  logic [CNT_W-1:0] score;
  logic [CNT_W-1:0] combo;
  modport master(output adv, spawn, key, input lights, hit, miss, score, combo);
  modport slave(input adv, spawn, key, output lights, hit, miss, score, combo);
endinterface

// File: rtl/ddr_lane.sv
// ddr_lane: one lane column with its row shift register, press detect and hit/miss judging
module ddr_lane import ddr_pkg::*; #(
  parameter int ROWS = ROWS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic spawn,
  input  logic key,
  output logic [ROWS-1:0] col,
  output logic hit,
  output logic miss,
  output logic hit_d,
  output logic miss_d,
  output logic wrong_d
);
  logic key_q;
  logic press;
  logic tgt_left;
  logic [ROWS-1:0] col_n;
  // a hit clears the target cell before any shift, so it can never also miss
  always_comb begin
    press = key & ~key_q;
    hit_d = press & col[ROWS-1];
    wrong_d = press & ~col[ROWS-1];
    tgt_left = col[ROWS-1] & ~hit_d;
    miss_d = adv & tgt_left;
    col_n = adv ? {col[ROWS-2:0], spawn} : {tgt_left, col[ROWS-2:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      key_q <= 1'b1;
      hit <= 1'b0;
      miss <= 1'b0;
    end else begin
      col <= col_n;
      key_q <= key;
      hit <= hit_d;
      miss <= miss_d;
    end
  end
endmodule

// File: rtl/ddr_note_lanes.sv
// ddr_note_lanes: scrolling LANES x ROWS note grid with per-lane judging and
// saturating score/combo aggregation
module ddr_note_lanes import ddr_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  ddr_note_lanes_if.slave bus
);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF >> (32 - CNT_W);
  logic [LANES-1:0] hit_d;
  logic [LANES-1:0] miss_d;
  logic [LANES-1:0] wrong_d;
  logic [LANES-1:0] hit_r;
  logic [LANES-1:0] miss_r;
  logic [LANES*ROWS-1:0] lights;
  logic [MAX_LANES-1:0] hit_x;
  logic [3:0] n_hit;
  logic [CNT_W-1:0] score;
  logic [CNT_W-1:0] combo;
  logic [ROWS-1:0] col [LANES];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ddr_lane #(.ROWS(ROWS)) u_lane (
      .clk(clk),
      .rst(rst),
      .adv(bus.adv),
      .spawn(bus.spawn[l]),
      .key(bus.key[l]),
      .col(col[l]),
      .hit(hit_r[l]),
      .miss(miss_r[l]),
      .hit_d(hit_d[l]),
      .miss_d(miss_d[l]),
      .wrong_d(wrong_d[l])
    );
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign lights[r*LANES+l] = col[l][r];
    end
  end
  always_comb begin
    hit_x = '0;
    hit_x[LANES-1:0] = hit_d;
    n_hit = popcount(hit_x);
  end
  // any miss or wrong press in the cycle beats the hit increment
  always_ff @(posedge clk) begin
    if (rst) begin
      score <= '0;
      combo <= '0;
    end else begin
      score <= CNT_W'(sat_add(32'(score), n_hit, CNT_MAX));
      combo <= (|miss_d || |wrong_d) ? '0 : CNT_W'(sat_add(32'(combo), n_hit, CNT_MAX));
    end
  end
  assign bus.lights = lights;
  assign bus.hit = hit_r;
  assign bus.miss = miss_r;
  assign bus.score = score;
  assign bus.combo = combo;
endmodule

// File: tb/tb_ddr_note_lanes.sv
// tb_ddr_note_lanes: directed scenarios with a pulse scoreboard for ddr_note_lanes
module tb_ddr_note_lanes;
  typedef struct {
    logic [3:0] hit;
    logic [3:0] miss;
    logic [7:0] score;
    logic [7:0] combo;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [3:0] kcur = 4'b0;
  exp_t q[$];
  exp_t mon_e;
  int s;
  int c;
  always #5 clk = ~clk;
  ddr_note_lanes_if #(.LANES(4), .ROWS(4), .CNT_W(8)) bus();
  ddr_note_lanes #(.LANES(4), .ROWS(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick(input logic a, input logic [3:0] sp, input logic [3:0] k);
    bus.adv = a;
    bus.spawn = sp;
    bus.key = k;
    kcur = k;
    @(posedge clk);
    #1;
  endtask
  task automatic advance(input logic [3:0] sp);
    tick(1'b1, sp, kcur);
    tick(1'b0, 4'b0, kcur);
  endtask
  task automatic expect_ev(input logic [3:0] h, input logic [3:0] m, input logic [7:0] sc, input logic [7:0] co);
    exp_t e;
    e.hit = h;
    e.miss = m;
    e.score = sc;
    e.combo = co;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (|bus.hit || |bus.miss) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected pulse: hit=%b miss=%b required none", bus.hit, bus.miss);
      end else begin
        mon_e = q.pop_front();
        chk("hit", 32'(bus.hit), 32'(mon_e.hit));
        chk("miss", 32'(bus.miss), 32'(mon_e.miss));
        chk("score", 32'(bus.score), 32'(mon_e.score));
        chk("combo", 32'(bus.combo), 32'(mon_e.combo));
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bus.adv = 1'b0;
    bus.spawn = 4'b0;
    bus.key = 4'b0;
    tick(1'b0, 4'b0, 4'b0);
    tick(1'b0, 4'b0, 4'b0);
    chk("rst_lights", 32'(bus.lights), 32'h0);
    chk("rst_hit", 32'(bus.hit), 32'h0);
    chk("rst_miss", 32'(bus.miss), 32'h0);
    chk("rst_score", 32'(bus.score), 32'h0);
    chk("rst_combo", 32'(bus.combo), 32'h0);
    rst = 1'b0;
    // single note in lane 0, hit after adv #4
    advance(4'b0001);
    chk("p1_row0", 32'(bus.lights), 32'h0001);
    advance(4'b0000);
    advance(4'b0000);
    advance(4'b0000);
    chk("p1_target", 32'(bus.lights), 32'h1000);
    expect_ev(4'b0001, 4'b0000, 8'd1, 8'd1);
    tick(1'b0, 4'b0, 4'b0001);
    chk("p1_cleared", 32'(bus.lights), 32'h0);
    tick(1'b0, 4'b0, 4'b0001);
    tick(1'b0, 4'b0, 4'b0000);
    // lane 0 hit, lane 1 left to miss
    advance(4'b0011);
    advance(4'b0000);
    advance(4'b0000);
    advance(4'b0000);
    chk("p2_target", 32'(bus.lights), 32'h3000);
    expect_ev(4'b0001, 4'b0000, 8'd2, 8'd2);
    tick(1'b0, 4'b0, 4'b0001);
    tick(1'b0, 4'b0, 4'b0000);
    expect_ev(4'b0000, 4'b0010, 8'd2, 8'd0);
    advance(4'b0000);
    chk("p2_empty", 32'(bus.lights), 32'h0);
    // press in the same cycle as the shifting adv
    advance(4'b0001);
    advance(4'b0000);
    advance(4'b0000);
    advance(4'b0000);
    expect_ev(4'b0001, 4'b0000, 8'd3, 8'd1);
    tick(1'b1, 4'b0, 4'b0001);
    tick(1'b0, 4'b0, 4'b0001);
    tick(1'b0, 4'b0, 4'b0000);
    chk("p3_empty", 32'(bus.lights), 32'h0);
    // key[2] pressed early on empty target and held: wrong press, then miss
    tick(1'b0, 4'b0, 4'b0100);
    chk("p4_wrong_combo", 32'(bus.combo), 32'd0);
    chk("p4_wrong_score", 32'(bus.score), 32'd3);
    advance(4'b0100);
    advance(4'b0000);
    advance(4'b0000);
    advance(4'b0000);
    chk("p4_target", 32'(bus.lights), 32'h4000);
    expect_ev(4'b0000, 4'b0100, 8'd3, 8'd0);
    advance(4'b0000);
    tick(1'b0, 4'b0, 4'b0000);
    // all lanes at once
    advance(4'b1111);
    advance(4'b0000);
    advance(4'b0000);
    advance(4'b0000);
    chk("p5_target", 32'(bus.lights), 32'hF000);
    expect_ev(4'b1111, 4'b0000, 8'd7, 8'd4);
    tick(1'b0, 4'b0, 4'b1111);
    tick(1'b0, 4'b0, 4'b0000);
    tick(1'b0, 4'b0, 4'b1000);
    chk("p5_wrong_combo", 32'(bus.combo), 32'd0);
    chk("p5_wrong_score", 32'(bus.score), 32'd7);
    tick(1'b0, 4'b0, 4'b0000);
    // pipelined full rows drive both counters into saturation
    s = 7;
    c = 0;
    for (int i = 0; i < 67; i++) begin
      tick(1'b1, (i < 64) ? 4'b1111 : 4'b0000, 4'b0000);
      if (i >= 3) begin
        s = (s + 4 > 255) ? 255 : s + 4;
        c = (c + 4 > 255) ? 255 : c + 4;
        expect_ev(4'b1111, 4'b0000, 8'(s), 8'(c));
        tick(1'b0, 4'b0, 4'b1111);
      end else begin
        tick(1'b0, 4'b0, 4'b0000);
      end
    end
    tick(1'b0, 4'b0, 4'b0000);
    chk("sat_score", 32'(bus.score), 32'd255);
    chk("sat_combo", 32'(bus.combo), 32'd255);
    chk("sat_empty", 32'(bus.lights), 32'h0);
    // reset mid-game with notes in flight and a key held
    advance(4'b0010);
    advance(4'b0100);
    advance(4'b1000);
    advance(4'b0001);
    chk("p6_grid", 32'(bus.lights), 32'h2481);
    tick(1'b0, 4'b0, 4'b0001);
    rst = 1'b1;
    tick(1'b1, 4'b0, 4'b0001);
    tick(1'b0, 4'b0, 4'b0001);
    tick(1'b1, 4'b0, 4'b0001);
    rst = 1'b0;
    chk("p6_lights", 32'(bus.lights), 32'h0);
    chk("p6_hit", 32'(bus.hit), 32'h0);
    chk("p6_miss", 32'(bus.miss), 32'h0);
    chk("p6_score", 32'(bus.score), 32'h0);
    chk("p6_combo", 32'(bus.combo), 32'h0);
    advance(4'b0001);
    advance(4'b0000);
    advance(4'b0000);
    advance(4'b0000);
    chk("p6_target", 32'(bus.lights), 32'h1000);
    expect_ev(4'b0000, 4'b0001, 8'd0, 8'd0);
    advance(4'b0000);
    tick(1'b0, 4'b0, 4'b0000);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
